// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
// The request type describes one cache-line miss. The state enum and the
// default response timeout are kept here with it.

`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH `ICACHE_LINE_WIDTH
`endif

package memory_arbiter_pkg;

    // Width of one cache line moved between memory and either cache.
    localparam int LINE_WIDTH = `ICACHE_LINE_WIDTH;

    // Default number of cycles to wait for memory before reporting a bus error.
    localparam int unsigned MEM_ARB_TIMEOUT = 256;

    // One cache-line miss request forwarded to the memory hierarchy.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
    } memory_request_t;

    // IDLE: free to grant a request.
    // WAIT_RSP: one transaction is outstanding and its response is awaited.
    // DRAIN: the transaction timed out, and its late response is discarded.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2
    } mem_arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester memory arbiter. Instruction-cache and data-cache miss requests
// are latched, granted one at a time with round-robin tie breaking, and
// forwarded as single-cycle pulses. Each response is routed back to the
// requester that owns the transaction. A timeout turns a missing response into
// a bus error, and the late response is then drained. Every output is a flop.

`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_ARB_TIMEOUT
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic                          ic_req_valid,
    input  memory_request_t               ic_req_info,
    output logic                          ic_rsp_valid,
    output logic                          ic_rsp_bus_error,

    input  logic                          dc_req_valid,
    input  memory_request_t               dc_req_info,
    output logic                          dc_rsp_valid,
    output logic                          dc_rsp_bus_error,

    output logic [`ICACHE_LINE_WIDTH-1:0] rsp_data,

    output logic                          mem_req_valid,
    output memory_request_t               mem_req_info,
    input  logic                          mem_rsp_valid,
    input  logic [`ICACHE_LINE_WIDTH-1:0] mem_rsp_data,
    input  logic                          mem_rsp_bus_error
);

    // Last count value before the wait is abandoned (WAIT_RSP) or given up (DRAIN).
    localparam logic [15:0] TERMINAL_COUNT = 16'(MEM_TIMEOUT - 1);

    mem_arb_state_t  state;
    mem_arb_state_t  state_next;

    logic            ic_pending;
    logic            dc_pending;
    memory_request_t ic_info;
    memory_request_t dc_info;

    logic            owner_dc;
    logic            prefer_dc;
    logic [15:0]     wait_count;

    logic            ic_want;
    logic            dc_want;
    logic            grant_dc;
    memory_request_t grant_info;
    logic            count_done;

    logic            do_grant;
    logic            do_deliver;
    logic            deliver_error;
    logic            count_clear;
    logic            count_inc;

    // A requester wants service if its request is already latched or arriving now.
    // On a tie the round-robin pointer decides. A latched request wins over a
    // fresh pulse, so the info captured first is the one that is forwarded.
    always_comb begin
        ic_want    = ic_pending | ic_req_valid;
        dc_want    = dc_pending | dc_req_valid;
        grant_dc   = dc_want & (~ic_want | prefer_dc);
        grant_info = '0;
        if (grant_dc) begin
            grant_info = dc_pending ? dc_info : dc_req_info;
        end else begin
            grant_info = ic_pending ? ic_info : ic_req_info;
        end
        count_done = (wait_count == TERMINAL_COUNT);
    end

    // Next-state logic and the control strobes that drive the datapath flops.
    // A response in the same cycle as the terminal count is treated as a normal
    // response, so no bus error is raised.
    always_comb begin
        state_next    = state;
        do_grant      = 1'b0;
        do_deliver    = 1'b0;
        deliver_error = 1'b0;
        count_clear   = 1'b0;
        count_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (ic_want || dc_want) begin
                    do_grant    = 1'b1;
                    count_clear = 1'b1;
                    state_next  = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    do_deliver = 1'b1;
                    state_next = IDLE;
                end else if (count_done) begin
                    do_deliver    = 1'b1;
                    deliver_error = 1'b1;
                    count_clear   = 1'b1;
                    state_next    = DRAIN;
                end else begin
                    count_inc = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_rsp_valid || count_done) begin
                    state_next = IDLE;
                end else begin
                    count_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending latches. A request is captured once and held until its response
    // (normal or timeout error) is delivered. A repeated pulse keeps the original info.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ic_pending <= 1'b0;
            ic_info    <= '0;
            dc_pending <= 1'b0;
            dc_info    <= '0;
        end else begin
            if (do_deliver && !owner_dc) begin
                ic_pending <= 1'b0;
            end else if (ic_req_valid && !ic_pending) begin
                ic_pending <= 1'b1;
                ic_info    <= ic_req_info;
            end
            if (do_deliver && owner_dc) begin
                dc_pending <= 1'b0;
            end else if (dc_req_valid && !dc_pending) begin
                dc_pending <= 1'b1;
                dc_info    <= dc_req_info;
            end
        end
    end

    // Ownership of the outstanding transaction and the round-robin pointer.
    // The pointer moves to the other requester when a transaction finishes.
    // After reset it favours the data cache.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_dc  <= 1'b0;
            prefer_dc <= 1'b1;
        end else begin
            if (do_grant) begin
                owner_dc <= grant_dc;
            end
            if (do_deliver) begin
                prefer_dc <= ~owner_dc;
            end
        end
    end

    // Cycle counter for the response timeout and for the drain window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_count <= '0;
        end else if (count_clear) begin
            wait_count <= '0;
        end else if (count_inc) begin
            wait_count <= wait_count + 16'd1;
        end
    end

    // Registered outputs. Valid and error flags are one-cycle pulses.
    // Request info and response data hold their last value between transactions.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_valid    <= 1'b0;
            mem_req_info     <= '0;
            ic_rsp_valid     <= 1'b0;
            ic_rsp_bus_error <= 1'b0;
            dc_rsp_valid     <= 1'b0;
            dc_rsp_bus_error <= 1'b0;
            rsp_data         <= '0;
        end else begin
            mem_req_valid    <= do_grant;
            ic_rsp_valid     <= do_deliver & ~owner_dc;
            dc_rsp_valid     <= do_deliver & owner_dc;
            ic_rsp_bus_error <= do_deliver & ~owner_dc & (deliver_error | mem_rsp_bus_error);
            dc_rsp_bus_error <= do_deliver & owner_dc & (deliver_error | mem_rsp_bus_error);
            if (do_grant) begin
                mem_req_info <= grant_info;
            end
            if (do_deliver) begin
                rsp_data <= deliver_error ? '0 : mem_rsp_data;
            end
        end
    end

    // A cache must not pulse a new request while its previous one is still latched.
    ic_reissue_check : assert property (@(posedge clock) disable iff (!reset)
        !(ic_req_valid && ic_pending));

    dc_reissue_check : assert property (@(posedge clock) disable iff (!reset)
        !(dc_req_valid && dc_pending));

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter, run with an 8-cycle timeout.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, so they reflect the edge that has just passed.

`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int unsigned TIMEOUT = 8;
    localparam int LW = `ICACHE_LINE_WIDTH;

    logic            clock;
    logic            reset;
    logic            ic_req_valid;
    memory_request_t ic_req_info;
    logic            ic_rsp_valid;
    logic            ic_rsp_bus_error;
    logic            dc_req_valid;
    memory_request_t dc_req_info;
    logic            dc_rsp_valid;
    logic            dc_rsp_bus_error;
    logic [LW-1:0]   rsp_data;
    logic            mem_req_valid;
    memory_request_t mem_req_info;
    logic            mem_rsp_valid;
    logic [LW-1:0]   mem_rsp_data;
    logic            mem_rsp_bus_error;

    int checks_done   = 0;
    int checks_failed = 0;
    int req_pulses    = 0;
    int pulse_base    = 0;

    memory_arbiter #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clock             (clock),
        .reset             (reset),
        .ic_req_valid      (ic_req_valid),
        .ic_req_info       (ic_req_info),
        .ic_rsp_valid      (ic_rsp_valid),
        .ic_rsp_bus_error  (ic_rsp_bus_error),
        .dc_req_valid      (dc_req_valid),
        .dc_req_info       (dc_req_info),
        .dc_rsp_valid      (dc_rsp_valid),
        .dc_rsp_bus_error  (dc_rsp_bus_error),
        .rsp_data          (rsp_data),
        .mem_req_valid     (mem_req_valid),
        .mem_req_info      (mem_req_info),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data),
        .mem_rsp_bus_error (mem_rsp_bus_error)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Counts the cycles in which a memory request pulse was present.
    always @(posedge clock) begin
        if (mem_req_valid === 1'b1) req_pulses++;
    end

    function automatic memory_request_t makeReq(input logic [31:0] addr);
        memory_request_t r;
        r.addr  = addr;
        r.write = 1'b0;
        return r;
    endfunction

    function automatic logic [LW-1:0] makeLine(input logic [31:0] word);
        return {4{word}};
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic icv, input memory_request_t ici,
                                 input logic dcv, input memory_request_t dci);
        ic_req_valid = icv;
        ic_req_info  = ici;
        dc_req_valid = dcv;
        dc_req_info  = dci;
    endtask

    task automatic memResponse(input logic v, input logic [LW-1:0] d, input logic e);
        mem_rsp_valid     = v;
        mem_rsp_data      = d;
        mem_rsp_bus_error = e;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks_done++;
        if (observed !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_req_valid"}, 128'(mem_req_valid), 128'(0));
        checkOutput({tag, "_mem_req_info"}, 128'(mem_req_info), 128'(0));
        checkOutput({tag, "_ic_rsp_valid"}, 128'(ic_rsp_valid), 128'(0));
        checkOutput({tag, "_ic_bus_error"}, 128'(ic_rsp_bus_error), 128'(0));
        checkOutput({tag, "_dc_rsp_valid"}, 128'(dc_rsp_valid), 128'(0));
        checkOutput({tag, "_dc_bus_error"}, 128'(dc_rsp_bus_error), 128'(0));
        checkOutput({tag, "_rsp_data"}, 128'(rsp_data), 128'(0));
    endtask

    // Directed scenarios with hand-computed cycle timing.
    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        memResponse(1'b0, '0, 1'b0);
        #2;
        checkAllZero("reset");
        @(posedge clock);
        #3;
        reset = 1'b1;
        waitCycles(1);

        // Single instruction-cache miss with a response a few cycles later.
        applyStimulus(1'b1, makeReq(32'h1000), 1'b0, '0);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s1_req_valid", 128'(mem_req_valid), 128'(1));
        checkOutput("s1_req_info", 128'(mem_req_info), 128'(makeReq(32'h1000)));
        checkOutput("s1_ic_rsp_early", 128'(ic_rsp_valid), 128'(0));
        waitCycles(1);
        checkOutput("s1_req_single_pulse", 128'(mem_req_valid), 128'(0));
        waitCycles(3);
        memResponse(1'b1, makeLine(32'hDEAD0001), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s1_ic_rsp_valid", 128'(ic_rsp_valid), 128'(1));
        checkOutput("s1_ic_bus_error", 128'(ic_rsp_bus_error), 128'(0));
        checkOutput("s1_dc_rsp_quiet", 128'(dc_rsp_valid), 128'(0));
        checkOutput("s1_rsp_data", 128'(rsp_data), 128'(makeLine(32'hDEAD0001)));
        waitCycles(1);
        checkOutput("s1_ic_rsp_pulse", 128'(ic_rsp_valid), 128'(0));

        // Tie after reset: data cache first. Then a second tie goes to the instruction cache.
        applyStimulus(1'b1, makeReq(32'h2000), 1'b1, makeReq(32'h3000));
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s2_first_valid", 128'(mem_req_valid), 128'(1));
        checkOutput("s2_first_is_dc", 128'(mem_req_info), 128'(makeReq(32'h3000)));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD0002), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s2_dc_rsp_valid", 128'(dc_rsp_valid), 128'(1));
        checkOutput("s2_ic_rsp_quiet", 128'(ic_rsp_valid), 128'(0));
        checkOutput("s2_dc_rsp_data", 128'(rsp_data), 128'(makeLine(32'hDEAD0002)));
        checkOutput("s2_no_req_yet", 128'(mem_req_valid), 128'(0));
        applyStimulus(1'b0, '0, 1'b1, makeReq(32'h3100));
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s2_ic_req_valid", 128'(mem_req_valid), 128'(1));
        checkOutput("s2_tie_to_ic", 128'(mem_req_info), 128'(makeReq(32'h2000)));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD0003), 1'b1);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s2_ic_rsp_valid", 128'(ic_rsp_valid), 128'(1));
        checkOutput("s2_ic_bus_error_pass", 128'(ic_rsp_bus_error), 128'(1));
        checkOutput("s2_ic_rsp_data", 128'(rsp_data), 128'(makeLine(32'hDEAD0003)));
        checkOutput("s2_dc_rsp_quiet", 128'(dc_rsp_valid), 128'(0));
        waitCycles(1);
        checkOutput("s2_dc_regrant_valid", 128'(mem_req_valid), 128'(1));
        checkOutput("s2_dc_regrant_info", 128'(mem_req_info), 128'(makeReq(32'h3100)));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD0004), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s2_dc_rsp2_valid", 128'(dc_rsp_valid), 128'(1));
        checkOutput("s2_dc_rsp2_error", 128'(dc_rsp_bus_error), 128'(0));
        waitCycles(2);

        // Timeout with no response, then a late response discarded in DRAIN.
        applyStimulus(1'b1, makeReq(32'h4000), 1'b0, '0);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s3_req_valid", 128'(mem_req_valid), 128'(1));
        waitCycles(TIMEOUT - 1);
        checkOutput("s3_no_early_error", 128'(ic_rsp_valid), 128'(0));
        waitCycles(1);
        checkOutput("s3_timeout_valid", 128'(ic_rsp_valid), 128'(1));
        checkOutput("s3_timeout_error", 128'(ic_rsp_bus_error), 128'(1));
        checkOutput("s3_timeout_data", 128'(rsp_data), 128'(0));
        checkOutput("s3_dc_quiet", 128'(dc_rsp_valid), 128'(0));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD0005), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s3_drain_ic_quiet", 128'(ic_rsp_valid), 128'(0));
        checkOutput("s3_drain_dc_quiet", 128'(dc_rsp_valid), 128'(0));
        checkOutput("s3_drain_data", 128'(rsp_data), 128'(0));
        checkOutput("s3_drain_no_req", 128'(mem_req_valid), 128'(0));
        waitCycles(1);

        // Data-cache request arriving during an instruction-cache transaction.
        pulse_base = req_pulses;
        applyStimulus(1'b1, makeReq(32'h5000), 1'b0, '0);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s4_ic_req_valid", 128'(mem_req_valid), 128'(1));
        checkOutput("s4_ic_req_info", 128'(mem_req_info), 128'(makeReq(32'h5000)));
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b1, makeReq(32'h6000));
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s4_no_second_issue", 128'(mem_req_valid), 128'(0));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD0006), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s4_ic_rsp_valid", 128'(ic_rsp_valid), 128'(1));
        checkOutput("s4_dc_not_yet", 128'(dc_rsp_valid), 128'(0));
        waitCycles(1);
        checkOutput("s4_dc_req_valid", 128'(mem_req_valid), 128'(1));
        checkOutput("s4_dc_req_info", 128'(mem_req_info), 128'(makeReq(32'h6000)));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD0007), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s4_dc_rsp_valid", 128'(dc_rsp_valid), 128'(1));
        checkOutput("s4_ic_rsp_quiet", 128'(ic_rsp_valid), 128'(0));
        checkOutput("s4_dc_rsp_data", 128'(rsp_data), 128'(makeLine(32'hDEAD0007)));
        waitCycles(2);
        checkOutput("s4_pulse_count", 128'(req_pulses - pulse_base), 128'(2));

        // A stray response while idle changes nothing.
        memResponse(1'b1, makeLine(32'hDEAD0008), 1'b1);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("idle_rsp_ic_quiet", 128'(ic_rsp_valid), 128'(0));
        checkOutput("idle_rsp_dc_quiet", 128'(dc_rsp_valid), 128'(0));
        checkOutput("idle_rsp_data_held", 128'(rsp_data), 128'(makeLine(32'hDEAD0007)));
        checkOutput("idle_rsp_no_req", 128'(mem_req_valid), 128'(0));

        // Reset in the middle of a transaction, then a stray response.
        applyStimulus(1'b0, '0, 1'b1, makeReq(32'h7000));
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s5_req_valid", 128'(mem_req_valid), 128'(1));
        waitCycles(2);
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("s5_in_reset");
        waitCycles(1);
        reset = 1'b1;
        memResponse(1'b1, makeLine(32'hDEAD0009), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s5_stray_ic_quiet", 128'(ic_rsp_valid), 128'(0));
        checkOutput("s5_stray_dc_quiet", 128'(dc_rsp_valid), 128'(0));
        checkOutput("s5_stray_data", 128'(rsp_data), 128'(0));
        applyStimulus(1'b1, makeReq(32'h8000), 1'b1, makeReq(32'h9000));
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s5_idle_grant", 128'(mem_req_valid), 128'(1));
        checkOutput("s5_tie_to_dc", 128'(mem_req_info), 128'(makeReq(32'h9000)));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD000A), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s5_dc_rsp_valid", 128'(dc_rsp_valid), 128'(1));
        waitCycles(1);
        checkOutput("s5_ic_req_info", 128'(mem_req_info), 128'(makeReq(32'h8000)));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD000B), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s5_ic_rsp_valid", 128'(ic_rsp_valid), 128'(1));
        waitCycles(1);

        // Response in the same cycle as the terminal count: normal completion.
        applyStimulus(1'b1, makeReq(32'hA000), 1'b0, '0);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s6_req_valid", 128'(mem_req_valid), 128'(1));
        waitCycles(TIMEOUT - 1);
        memResponse(1'b1, makeLine(32'hDEAD000C), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s6_ic_rsp_valid", 128'(ic_rsp_valid), 128'(1));
        checkOutput("s6_ic_no_error", 128'(ic_rsp_bus_error), 128'(0));
        checkOutput("s6_rsp_data", 128'(rsp_data), 128'(makeLine(32'hDEAD000C)));
        applyStimulus(1'b0, '0, 1'b1, makeReq(32'hB000));
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("s6_back_in_idle", 128'(mem_req_valid), 128'(1));
        checkOutput("s6_next_info", 128'(mem_req_info), 128'(makeReq(32'hB000)));
        waitCycles(1);
        memResponse(1'b1, makeLine(32'hDEAD000D), 1'b0);
        waitCycles(1);
        memResponse(1'b0, '0, 1'b0);
        checkOutput("s6_dc_rsp_valid", 128'(dc_rsp_valid), 128'(1));
        waitCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low, and the ports are named as follows.
REQ-002 Parameter MEM_TIMEOUT, default 256: cycles to wait for a memory response before a bus error is reported; legal range 2..65535.
REQ-003 clock  in  1  system clock, all flops on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ic_req_valid  in  1  single-cycle miss request pulse from the instruction cache.
REQ-006 ic_req_info  in  memory_request_t  instruction-cache miss request, sampled with ic_req_valid.
REQ-007 ic_rsp_valid / ic_rsp_bus_error  out  1 / 1  response pulse and error flag to the instruction cache.
REQ-008 dc_req_valid / dc_req_info  in  1 / memory_request_t  data-cache miss request, same rules as the instruction-cache side.
REQ-009 dc_rsp_valid / dc_rsp_bus_error  out  1 / 1  response pulse and error flag to the data cache.
REQ-010 rsp_data  out  `ICACHE_LINE_WIDTH  response line, shared by both caches and valid with either rsp_valid; `DCACHE_LINE_WIDTH equals `ICACHE_LINE_WIDTH.
REQ-011 mem_req_valid / mem_req_info  out  1 / memory_request_t  single-cycle request pulse to the memory hierarchy.
REQ-012 mem_rsp_valid / mem_rsp_data / mem_rsp_bus_error  in  1 / line / 1  memory response.

Function
REQ-013 Per-requester pending latch: set on req_valid (info captured), cleared when that requester's response is delivered.
REQ-014 States: IDLE, WAIT_RSP, DRAIN.
REQ-015 In IDLE, when a pending latch or an incoming req_valid is present, the block SHALL grant one requester, drive mem_req_valid high for exactly the next cycle with the granted info, and enter WAIT_RSP.
- Best-case latency: request sampled at edge N, mem_req_valid high in cycle N+1.
REQ-016 Arbitration: if only one requester is pending, it is granted. If both are pending, round-robin applies: the requester not granted last wins. After reset, the data cache wins the first tie.
REQ-017 Only one memory transaction SHALL be outstanding; no mem_req_valid is issued outside IDLE.
REQ-018 In WAIT_RSP, when mem_rsp_valid is sampled at edge M:
- the owner's rsp_valid is high for one cycle in M+1, with rsp_data and bus_error registered from the memory response;
- the other rsp_valid stays 0;
- the owner's pending latch clears, the round-robin pointer updates, and the state returns to IDLE.
REQ-019 A 16-bit timeout counter SHALL clear on entry to WAIT_RSP and count every cycle spent there. On reaching MEM_TIMEOUT-1 without a response:
- the owner receives rsp_valid with bus_error=1 and rsp_data all zeros;
- the state moves to DRAIN.
REQ-020 In DRAIN, the first mem_rsp_valid SHALL be discarded and the state returns to IDLE. If no response arrives within MEM_TIMEOUT cycles, the state returns to IDLE anyway.
REQ-021 A mem_rsp_valid sampled in IDLE SHALL be ignored and SHALL NOT change any state or output.
REQ-022 A request from the non-owner arriving during WAIT_RSP or DRAIN SHALL be latched and served next; no request is lost.
REQ-023 A new req_valid from a requester whose latch is already set is a protocol violation; an assertion SHALL flag it and the latched info SHALL be kept.
REQ-024 If mem_rsp_valid and the timeout terminal count fall in the same cycle, the response wins and no bus error is generated.
REQ-025 All outputs SHALL be driven from flops; there is no combinational path from input to output.

Reset
REQ-026 While reset=0, all outputs SHALL be 0: mem_req_valid, mem_req_info, both rsp_valid, both bus_error, and rsp_data.
REQ-027 Reset SHALL also force state=IDLE, clear both pending latches, clear the counter, and set the round-robin pointer to favour the data cache.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction. No response is delivered afterwards; a late mem_rsp_valid lands in IDLE and is ignored per REQ-021.

Structure
REQ-029 The arbiter state enum mem_arb_state_t and the default MEM_ARB_TIMEOUT constant SHALL live in the shared package alongside memory_request_t; no new request/response typedefs are introduced.
REQ-030 No sub-module is needed; arbitration, the counter and the FSM are implemented inline, in 120-400 lines.

Verification
REQ-031 Bench directed scenarios:
- ic_req_valid pulse, addr 0x1000, memory responds 5 cycles later -> mem_req_valid 1 cycle after the request; ic_rsp_valid 1 cycle after mem_rsp_valid; dc_rsp_valid stays 0.
- ic and dc request in the same cycle -> dc is granted first; ic's mem_req_valid is issued 2 cycles after dc's response; the next tie goes to ic.
- MEM_TIMEOUT=8, no response -> owner gets rsp_valid with bus_error=1 8 cycles after the grant; a late response at cycle 10 is discarded in DRAIN.
- dc request during an outstanding ic transaction -> dc is served immediately after ic completes; exactly 2 mem_req_valid pulses in total.
- reset pulled low 3 cycles after a grant, then a stray mem_rsp_valid -> no rsp_valid on either side; all outputs 0; FSM in IDLE.
- mem_rsp_valid in the same cycle as the timeout terminal count -> normal response with bus_error=0, followed by IDLE (not DRAIN).
